// File: rtl/sha_round_sequencer_if.sv
// Handshake and data bundle between job control, the round
// sequencer and the SHA-256 compression datapath.
interface sha_round_sequencer_if;
    logic         start_i;
    logic         busy_o;
    logic         done_o;
    logic [5:0]   round_o;
    logic [31:0]  kt_o;
    logic [255:0] h1_i;
    logic [255:0] digest_o;

    modport master (
        output start_i,
        output h1_i,
        input  busy_o,
        input  done_o,
        input  round_o,
        input  kt_o,
        input  digest_o
    );

    modport slave (
        input  start_i,
        input  h1_i,
        output busy_o,
        output done_o,
        output round_o,
        output kt_o,
        output digest_o
    );
endinterface

// File: rtl/sha_round_sequencer.sv
// Steps one SHA-256 compression datapath through 64 rounds,
// supplies round index and Kt, and captures the final H1.
module sha_round_sequencer (
    input  logic               clk,
    input  logic               reset_n,
    sha_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAPTURE
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t       state;
    logic [5:0]   round_q;
    logic [31:0]  kt_q;
    logic         busy_q;
    logic         done_q;
    logic [255:0] digest_q;

    // Kt trails the round index by one cycle to match the
    // datapath, which consumes Kt the cycle after it loads Wt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            round_q  <= 6'd0;
            kt_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digest_q <= 256'd0;
        end else begin
            kt_q   <= K[round_q];
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    round_q <= 6'd0;
                    if (bus.start_i) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    round_q <= round_q + 6'd1;
                    if (round_q == 6'd63) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    digest_q <= bus.h1_i;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    round_q <= 6'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.round_o  = round_q;
    assign bus.kt_o     = kt_q;
    assign bus.digest_o = digest_q;
endmodule

// File: tb/tb_sha_round_sequencer.sv
// Bench for sha_round_sequencer with a behavioural SHA-256
// datapath driven by the sequencer's round index and Kt.
module tb_sha_round_sequencer;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] ABC_MSG = {32'h61626380, 448'h0, 32'h18};

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    sha_round_sequencer_if bus ();

    sha_round_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_round(
        input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
               + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
               + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add8(
        input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [31:0] sched(input logic [511:0] m, input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = m[511 - i*32 -: 32];
            else w[i] = w[i-16] + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        end
        return w[t];
    endfunction

    // Reference: plain FIPS 180-4 compression of one block.
    function automatic logic [255:0] compress(
        input logic [255:0] h0, input logic [511:0] m);
        logic [255:0] s;
        s = h0;
        for (int t = 0; t < 64; t++) s = sha_round(s, KT[t], sched(m, t));
        return add8(h0, s);
    endfunction

    // Datapath model: loads H0/Wt on the round given, uses Kt a cycle later.
    logic [255:0] h0v;
    logic [511:0] msg;
    logic [31:0]  wsched [64];
    logic [255:0] dp_st;
    logic [31:0]  dp_w;

    always @(posedge clk) begin
        if (bus.busy_o === 1'b1) begin
            if (bus.round_o == 6'd0) begin
                dp_st <= h0v;
                dp_w  <= wsched[0];
            end else begin
                dp_st <= sha_round(dp_st, bus.kt_o, dp_w);
                dp_w  <= wsched[bus.round_o];
            end
        end
    end

    assign bus.h1_i = add8(h0v, sha_round(dp_st, bus.kt_o, dp_w));

    task automatic set_job(input logic [255:0] h, input logic [511:0] m);
        h0v = h;
        msg = m;
        for (int t = 0; t < 64; t++) wsched[t] = sched(m, t);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulses start from IDLE and waits (bounded) for done.
    task automatic run_job(output logic [255:0] dg, output int lat);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        lat = -1;
        dg = '0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (bus.done_o === 1'b1) begin
                lat = c;
                dg = bus.digest_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [255:0] dg;
        int lat;
        set_job(IV, ABC_MSG);
        run_job(dg, lat);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({bus.busy_o, bus.done_o, bus.round_o, bus.kt_o} !== 40'd0) begin
            bad++;
            $display("FAIL reset_ctl got busy=%b done=%b round=%0d kt=%h want 0",
                     bus.busy_o, bus.done_o, bus.round_o, bus.kt_o);
        end
        total++;
        if (bus.digest_o !== 256'd0) begin
            bad++;
            $display("FAIL reset_digest got %h want 0", bus.digest_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        total++;
        if (bus.kt_o !== 32'h428a2f98 || bus.round_o !== 6'd0) begin
            bad++;
            $display("FAIL reset_kt0 got kt=%h round=%0d want 428a2f98/0",
                     bus.kt_o, bus.round_o);
        end
    endtask

    task automatic test_alignment();
        logic [31:0] ekt;
        logic [5:0]  ernd;
        logic        ebusy, edone;
        set_job(IV, ABC_MSG);
        bus.start_i = 1'b1;
        for (int n = 0; n <= 66; n++) begin
            tick();
            bus.start_i = 1'b0;
            ernd  = (n <= 63) ? n[5:0] : 6'd0;
            ekt   = KT[(n >= 1 && n <= 64) ? n - 1 : 0];
            ebusy = (n <= 64);
            edone = (n == 65);
            total++;
            if (bus.round_o !== ernd || bus.kt_o !== ekt) begin
                bad++;
                $display("FAIL align_n%0d got round=%0d kt=%h want %0d/%h",
                         n, bus.round_o, bus.kt_o, ernd, ekt);
            end
            total++;
            if (bus.busy_o !== ebusy || bus.done_o !== edone) begin
                bad++;
                $display("FAIL flags_n%0d got busy=%b done=%b want %b/%b",
                         n, bus.busy_o, bus.done_o, ebusy, edone);
            end
        end
    endtask

    task automatic test_abc();
        logic [255:0] dg;
        int lat;
        set_job(IV, ABC_MSG);
        run_job(dg, lat);
        total++;
        if (lat != 65) begin
            bad++;
            $display("FAIL abc_latency got %0d want 65", lat);
        end
        total++;
        if (dg !== ABC_DIGEST) begin
            bad++;
            $display("FAIL abc_digest got %h want %h", dg, ABC_DIGEST);
        end
    endtask

    task automatic test_random();
        logic [255:0] h, dg, exp;
        logic [511:0] m;
        int lat;
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom();
            for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom();
            set_job(h, m);
            exp = compress(h, m);
            repeat ($urandom_range(0, 5)) tick();
            run_job(dg, lat);
            total++;
            if (lat != 65 || dg !== exp) begin
                bad++;
                $display("FAIL rand%0d got lat=%0d dg=%h want 65/%h",
                         j, lat, dg, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic edone;
        int   ndone;
        logic [255:0] exp;
        set_job(IV, ABC_MSG);
        exp = compress(IV, ABC_MSG);
        ndone = 0;
        bus.start_i = 1'b1;
        for (int c = 0; c < 4 * 66; c++) begin
            tick();
            if (c == 4 * 66 - 1) bus.start_i = 1'b0;
            edone = (c >= 65) && ((c - 65) % 66 == 0);
            total++;
            if (bus.done_o !== edone) begin
                bad++;
                $display("FAIL b2b_done_c%0d got %b want %b", c, bus.done_o, edone);
            end
            if (bus.done_o === 1'b1) begin
                ndone++;
                total++;
                if (bus.digest_o !== exp) begin
                    bad++;
                    $display("FAIL b2b_digest_c%0d got %h want %h",
                             c, bus.digest_o, exp);
                end
            end
        end
        total++;
        if (ndone != 4) begin
            bad++;
            $display("FAIL b2b_count got %0d want 4", ndone);
        end
    endtask

    task automatic test_reset_midrun();
        logic [255:0] dg;
        int lat;
        bit hit;
        int ndone;
        set_job(IV, ABC_MSG);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        hit = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.round_o === 6'd30) begin
                hit = 1;
                break;
            end
            tick();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL midrun_reach30 got round=%0d want 30", bus.round_o);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus.busy_o !== 1'b0 || bus.digest_o !== 256'd0
            || bus.done_o !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset got busy=%b done=%b dg=%h want 0/0/0",
                     bus.busy_o, bus.done_o, bus.digest_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL midrun_quiet got %0d active cycles want 0", ndone);
        end
        run_job(dg, lat);
        total++;
        if (lat != 65 || dg !== ABC_DIGEST) begin
            bad++;
            $display("FAIL midrun_rerun got lat=%0d dg=%h want 65/%h",
                     lat, dg, ABC_DIGEST);
        end
    endtask

    task automatic test_idle();
        logic [255:0] d;
        int lat;
        set_job(IV, ABC_MSG);
        run_job(d, lat);
        for (int c = 0; c < 200; c++) begin
            tick();
            total++;
            if (bus.digest_o !== d || bus.done_o !== 1'b0
                || bus.round_o !== 6'd0 || bus.busy_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_c%0d got dg=%h done=%b round=%0d want %h/0/0",
                         c, bus.digest_o, bus.done_o, bus.round_o, d);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        bus.start_i = 1'b0;
        set_job(IV, ABC_MSG);
        dp_st = '0;
        dp_w = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick();
        test_reset();
        test_alignment();
        test_abc();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha_round_sequencer.md
Name: sha_round_sequencer

Overview:
- Drives the externally managed state of the SHA-256 compression datapath: the 6-bit round index and the per-round constant Kt.
- Accepts a start request, steps the datapath through 64 rounds and captures the finished 256-bit H1 into a result register, then signals done.
- Sits between the mining/job control logic and one compression datapath. M and H0 are routed directly to the datapath and must be held stable by the requester while busy_o is high.

Parameters:
- none. Round count is fixed at 64. K constants are the FIPS 180-4 SHA-256 set held in an internal 64x32 ROM.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start_i  input  1  request a compression; sampled only in IDLE
- busy_o  output  1  high while a compression is in progress
- done_o  output  1  single-cycle pulse; digest_o valid from this cycle
- round_o  output  6  round index to datapath
- kt_o  output  32  round constant to datapath
- h1_i  input  256  H1 result from datapath
- digest_o  output  256  captured H1 of last completed compression

Behaviour:
- Reset (async, reset_n low): state=IDLE, round_o=0, kt_o=0, busy_o=0, done_o=0, digest_o=0. Reset mid-operation aborts immediately; no done_o and digest_o is cleared.
- States: IDLE, RUN, CAPTURE.
- kt_o is registered every cycle outside reset as K[round_o], so kt_o lags round_o by exactly one cycle. The datapath registers H0/Wt on the round it is given and consumes Kt one cycle later.
- Edge numbering: E0 is the edge that samples start_i=1 in IDLE; En is the n-th edge after E0.
- IDLE:
  - start_i=1 at E0 -> RUN, round_o=0, busy_o=1.
  - start_i=0 -> stay in IDLE, round_o held 0.
- RUN: each edge increments round_o. At the edge where round_o=63 (E64) -> round_o wraps to 0, state=CAPTURE.
  - Wrap is harmless: the datapath reloads H0 on round 0.
- CAPTURE (cycle between E64 and E65): h1_i holds the final result.
  - At E65: digest_o<=h1_i, done_o<=1, busy_o<=0, state=IDLE.
- done_o: high for exactly one cycle (E65..E66), then 0. Latency start-sample to done_o high = 65 clocks.
- start_i while busy (RUN/CAPTURE): ignored, not queued.
- start_i high in the done_o cycle: accepted (state is IDLE). Back-to-back throughput is one compression per 66 clocks.
- digest_o holds its value until the next capture or reset. It is never partially updated.
- round_o increment is modulo 64. No other arithmetic.
- Requester obligation: M and H0 stable from E0 through E65. Changing them while busy_o is high gives an undefined digest. The sequencer does not check this.

Test Plan:
- Reset values: assert reset_n=0 asynchronously mid-cycle -> all outputs 0 immediately. After release and one clock, kt_o=0x428a2f98 (K[0], round_o=0).
- Constant alignment: pulse start -> round_o = 0,1,...,63 on cycles 0..63 after E0. kt_o=0x428a2f98 in the cycle round_o=1, and kt_o=0xc67178f2 in the CAPTURE cycle. done_o high exactly 65 clocks after E0.
- End-to-end with the compression datapath, H0 = standard IV (6a09e667 ... 5be0cd19), M = padded "abc" (0x61626380, zeros, length word 0x18) -> digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Start while busy: hold start_i=1 continuously -> exactly one done_o pulse per 66 clocks. Each digest is correct, with no extra or shortened runs.
- Reset mid-run: deassert reset_n at round_o=30 -> busy_o=0, digest_o=0, no done_o. Fresh start afterwards reproduces the "abc" digest.
- Idle stability: start_i=0 for 200 cycles after a completed run -> digest_o unchanged, done_o stays 0, round_o stays 0.
